// File: rtl/array_row_serializer.sv
// Captures one ROWS x COLS array via valid/ready and replays it one packed row per beat.
// Optional ARRAY_ROW_SERIALIZER_TRACE_EN adds a registered diagonal-sum output (trace_o).
module array_row_serializer #(
    parameter int BIT_WIDTH = 4,
    parameter int ROWS      = 8,
    parameter int COLS      = 8,
    localparam int IDX_W    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] in_i,
    input  logic                                     in_valid_i,
    output logic                                     in_ready_o,
    output logic [COLS*BIT_WIDTH-1:0]                out_row_o,
    output logic [IDX_W-1:0]                         out_idx_o,
    output logic                                     out_last_o,
    output logic                                     out_valid_o,
    input  logic                                     out_ready_i
`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
    ,
    output logic [BIT_WIDTH+$clog2((ROWS < COLS) ? ROWS : COLS)-1:0] trace_o
`endif
);

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROWS - 1);

    state_t                                   state_q, state_d;
    logic [IDX_W-1:0]                         row_idx_q, row_idx_d;
    logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] buf_q;
    logic                                     capture_s;
    logic                                     at_last_s;

    assign at_last_s = (row_idx_q == LAST_IDX);

    // Next-state logic: capture in IDLE, advance one row per accepted beat in SEND.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        capture_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    capture_s = 1'b1;
                    row_idx_d = {IDX_W{1'b0}};
                    state_d   = SEND;
                end else begin
                    state_d   = IDLE;
                end
            end
            SEND: begin
                if (out_ready_i) begin
                    if (at_last_s) begin
                        state_d   = IDLE;
                    end else begin
                        row_idx_d = row_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = SEND;
                end
            end
            default: begin
                state_d   = IDLE;
                row_idx_d = {IDX_W{1'b0}};
            end
        endcase
    end

    // Output decode; the row mux reads the buffer only, so stalls hold out_* stable.
    always_comb begin
        in_ready_o  = (state_q == IDLE);
        out_valid_o = (state_q == SEND);
        out_idx_o   = row_idx_q;
        out_last_o  = (state_q == SEND) && at_last_s;
        out_row_o   = {(COLS*BIT_WIDTH){1'b0}};
        for (int r = 0; r < ROWS; r++) begin
            if (row_idx_q == IDX_W'(r)) begin
                out_row_o = buf_q[r];
            end else begin
                out_row_o = out_row_o;
            end
        end
    end

    // State, row pointer and capture buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_idx_q <= {IDX_W{1'b0}};
            buf_q     <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            if (capture_s) begin
                buf_q <= in_i;
            end
        end
    end

`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
    localparam int DIAG    = (ROWS < COLS) ? ROWS : COLS;
    localparam int TRACE_W = BIT_WIDTH + $clog2(DIAG);

    function automatic logic [TRACE_W-1:0] diag_sum(
        input logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] a
    );
        logic [TRACE_W-1:0] s;
        s = {TRACE_W{1'b0}};
        for (int i = 0; i < DIAG; i++) begin
            s = s + TRACE_W'(a[i][i]);
        end
        return s;
    endfunction

    // Diagonal sum is latched alongside the buffer and held until the next capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_o <= {TRACE_W{1'b0}};
        end else if (capture_s) begin
            trace_o <= diag_sum(in_i);
        end
    end
`endif

endmodule

// File: tb/tb_array_row_serializer.sv
// Randomized self-checking bench: a queue of expected rows models the serializer.
module tb_array_row_serializer;

    typedef logic [7:0][7:0][3:0] arr_t;
    typedef struct {
        logic [31:0] row;
        int          idx;
        bit          last;
    } beat_t;

    logic        clk;
    logic        rst_n;
    arr_t        in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_row;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
    logic [6:0]  trace;
    logic [3:0]  trace1;
`endif

    logic [0:0][2:0][3:0] in1;
    logic        in_valid1, in_ready1, out_last1, out_valid1, out_ready1;
    logic [11:0] out_row1;
    logic [0:0]  out_idx1;

    beat_t exp_q[$];
    int    exp_trace;
    int    n_checks;
    int    n_pass;

    array_row_serializer #(.BIT_WIDTH(4), .ROWS(8), .COLS(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_i(in_data), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .out_row_o(out_row), .out_idx_o(out_idx),
        .out_last_o(out_last), .out_valid_o(out_valid), .out_ready_i(out_ready)
`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
        , .trace_o(trace)
`endif
    );

    array_row_serializer #(.BIT_WIDTH(4), .ROWS(1), .COLS(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_i(in1), .in_valid_i(in_valid1),
        .in_ready_o(in_ready1), .out_row_o(out_row1), .out_idx_o(out_idx1),
        .out_last_o(out_last1), .out_valid_o(out_valid1), .out_ready_i(out_ready1)
`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
        , .trace_o(trace1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic arr_t rand_arr();
        arr_t a;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                a[r][c] = 4'($urandom_range(0, 15));
        return a;
    endfunction

    task automatic model_capture(input arr_t a);
        beat_t b;
        exp_trace = 0;
        for (int r = 0; r < 8; r++) begin
            b.row = 32'd0;
            for (int c = 0; c < 8; c++)
                b.row = b.row | (32'(a[r][c]) << (c * 4));
            b.idx  = r;
            b.last = (r == 7);
            exp_q.push_back(b);
            exp_trace = exp_trace + int'(a[r][r]);
        end
    endtask

    // Called at a negedge: check outputs against the model, drive inputs, advance one cycle.
    task automatic cycle(input logic v, input arr_t d, input logic r);
        check_eq("in_ready", in_ready, exp_q.size() == 0);
        check_eq("out_valid", out_valid, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_eq("out_row", out_row, exp_q[0].row);
            check_eq("out_idx", out_idx, exp_q[0].idx);
            check_eq("out_last", out_last, exp_q[0].last);
`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
            check_eq("trace", trace, exp_trace);
`endif
        end
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        if (exp_q.size() == 0) begin
            if (v) model_capture(d);
        end else if (r) begin
            void'(exp_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) cycle(1'b0, '0, 1'b1);
        check_eq("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        arr_t a;
        n_checks = 0; n_pass = 0; exp_trace = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        in_valid1 = 1'b0; in1 = '0; out_ready1 = 1'b0;
        #3;
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_out_last", out_last, 0);
        check_eq("rst_out_idx", out_idx, 0);
        check_eq("rst_out_row", out_row, 0);
`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
        check_eq("rst_trace", trace, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Diagonal of 5s with a consumer that never stalls.
        a = '0;
        for (int i = 0; i < 8; i++) a[i][i] = 4'h5;
        cycle(1'b1, a, 1'b1);
`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
        check_eq("diag_trace", trace, 40);
`endif
        for (int k = 0; k < 8; k++) begin
            check_eq("diag_row", out_row, 32'h5 << (4 * k));
            check_eq("diag_last", out_last, k == 7);
            cycle(1'b0, '0, 1'b1);
        end
        check_eq("diag_bubble_ready", in_ready, 1);
        cycle(1'b0, '0, 1'b1);

        // Random stalls with in_valid mostly held and data changing every cycle.
        for (int n = 0; n < 300; n++)
            cycle(($urandom_range(0, 9) < 8), rand_arr(), $urandom_range(0, 1) == 1);
        drain();

        // Back-to-back arrays: in_valid held high throughout.
        for (int n = 0; n < 20; n++) cycle(1'b1, rand_arr(), 1'b1);
        drain();

`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
        a = '1;
        cycle(1'b1, a, 1'b1);
        check_eq("allf_trace", trace, 7'd120);
        drain();
`endif

        // Reset pulse after three beats.
        cycle(1'b1, rand_arr(), 1'b1);
        for (int k = 0; k < 3; k++) cycle(1'b0, '0, 1'b1);
        check_eq("pre_rst_idx", out_idx, 3);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_out_valid", out_valid, 0);
        check_eq("mid_rst_in_ready", in_ready, 1);
        check_eq("mid_rst_out_idx", out_idx, 0);
        exp_q.delete();
        exp_trace = 0;
        #1 rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b1, rand_arr(), 1'b0);
        check_eq("post_rst_idx", out_idx, 0);
        for (int n = 0; n < 30; n++) cycle(1'b0, '0, $urandom_range(0, 1) == 1);
        drain();

        // Single-row instance: one beat carries the whole array.
        check_eq("r1_in_ready", in_ready1, 1);
        in1 = 12'hA3F;
        in_valid1 = 1'b1;
        out_ready1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid1 = 1'b0;
        check_eq("r1_out_valid", out_valid1, 1);
        check_eq("r1_out_row", out_row1, 12'hA3F);
        check_eq("r1_out_last", out_last1, 1);
        check_eq("r1_out_idx", out_idx1, 0);
`ifdef ARRAY_ROW_SERIALIZER_TRACE_EN
        check_eq("r1_trace", trace1, 4'hF);
`endif
        @(posedge clk);
        @(negedge clk);
        check_eq("r1_done_valid", out_valid1, 0);
        check_eq("r1_done_ready", in_ready1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
